shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 14 +
 rtl/shift_sequencer_barrel_shifter_8bit.sv | 20 ++
 rtl/shift_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift sequencer: FSM states, per-pass
// shift limit and operand width.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned MAX_PASS = 7;
  localparam int unsigned WORD_W   = 8;

endpackage

// File: rtl/shift_sequencer_barrel_shifter_8bit.sv
// 8-bit logical right barrel shifter, 0..7 positions, built as three
// power-of-two stages selected by the ctrl bits.
module barrel_shifter_8bit
  import shift_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        ctrl,
  output logic [WORD_W-1:0] result
);

  logic [WORD_W-1:0] stage1;
  logic [WORD_W-1:0] stage2;

  always_comb begin
    stage1 = ctrl[0] ? (data >> 1)   : data;
    stage2 = ctrl[1] ? (stage1 >> 2) : stage1;
    result = ctrl[2] ? (stage2 >> 4) : stage2;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass logical right shifter: large shift amounts are split into passes
// of at most MAX_PASS through one 8-bit barrel shifter. Define SHIFT_STICKY_EN
// to add the out_sticky output (OR of all bits shifted out).
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned AMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              busy
`ifdef SHIFT_STICKY_EN
  ,
  output logic              out_sticky
`endif
);

  state_t            state;
  logic [WORD_W-1:0] data_q;
  logic [AMT_W-1:0]  rem;
  logic [2:0]        pass;
  logic [AMT_W-1:0]  rem_next;
  logic [WORD_W-1:0] shifted;

  always_comb begin
    pass     = (rem > AMT_W'(MAX_PASS)) ? 3'(MAX_PASS) : rem[2:0];
    rem_next = rem - AMT_W'(pass);
  end

  barrel_shifter_8bit u_shifter (
    .data   (data_q),
    .ctrl   (pass),
    .result (shifted)
  );

`ifdef SHIFT_STICKY_EN
  logic              sticky;
  logic [WORD_W-1:0] lost_mask;

  // Low 'pass' bits of the data register are the ones this pass discards.
  always_comb begin
    lost_mask = (WORD_W'(1) << pass) - WORD_W'(1);
  end

  assign out_sticky = sticky;
`endif

  assign out_data = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
`ifdef SHIFT_STICKY_EN
      sticky    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            rem      <= in_amt;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SHIFT_STICKY_EN
            sticky   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          data_q <= shifted;
          rem    <= rem_next;
`ifdef SHIFT_STICKY_EN
          sticky <= sticky | (|(data_q & lost_mask));
`endif
          if (rem_next == '0) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
